// File: rtl/retire_unit_pkg.sv
// Shared types for the retirement stage: ROB commit packet, register-name
// typedefs and the retire FSM state encoding.
// Optional feature macro used by this slice: RETIRE_TRACE_EN.

`ifndef N
`define N 4
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

package retire_unit_pkg;
  localparam int N_CT        = `N;
  localparam int PHYS_REG_SZ = `PHYS_REG_SZ;
  localparam int ARCH_REG_SZ = 32;
  localparam int PRN_W       = $clog2(PHYS_REG_SZ);
  localparam int ARN_W       = $clog2(ARCH_REG_SZ);

  typedef logic [PRN_W-1:0] PRN;
  typedef logic [ARN_W-1:0] ARN;

  // One ROB commit slot.
  typedef struct packed {
    logic [31:0] PC;
    logic        executed;
    logic        halt;
    logic        illegal;
    logic        is_store;
    ARN          dest_arn;
    PRN          dest_prn;
  } ROB_ENTRY;

  typedef struct packed {
    ROB_ENTRY [N_CT-1:0] entries;
  } ROB_CT_PACKET;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } RETIRE_STATE;
endpackage

// File: rtl/retire_map_update.sv
// Combinational map walk over one commit packet: applies the slots in order,
// reports the superseded PRNs, and stops at the first invalid or halting slot.

module retire_map_update
  import retire_unit_pkg::*;
#(
  parameter int N           = `N,
  parameter int ARCH_REG_SZ = 32,
  parameter int CW          = $clog2(N + 1)
) (
  input  PRN [ARCH_REG_SZ-1:0] i_map,
  input  ROB_CT_PACKET         i_pkt,
  output PRN [ARCH_REG_SZ-1:0] o_map,
  output logic [N-1:0]         o_free_valid,
  output PRN [N-1:0]           o_free_prn,
  output logic [CW-1:0]        o_retire_cnt,
  output logic [CW-1:0]        o_store_cnt,
  output logic                 o_halt_hit,
  output logic                 o_illegal_hit
);

  logic         w_stop;
  logic [N-1:0] w_unused_pc;

  // PC only matters to the optional trace path in the parent.
  for (genvar gi = 0; gi < N; gi++) begin : g_pc
    assign w_unused_pc[gi] = ^i_pkt.entries[gi].PC;
  end

  // Sequential slot walk; o_retire_cnt doubles as the stop index.
  always_comb begin
    o_map         = i_map;
    o_free_valid  = '0;
    o_free_prn    = '0;
    o_retire_cnt  = '0;
    o_store_cnt   = '0;
    o_halt_hit    = 1'b0;
    o_illegal_hit = 1'b0;
    w_stop        = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_stop) begin
        if (!i_pkt.entries[i].executed) begin
          w_stop = 1'b1;
        end else begin
          o_retire_cnt = o_retire_cnt + CW'(1);
          if (i_pkt.entries[i].is_store) o_store_cnt = o_store_cnt + CW'(1);
          // Register 0 is hardwired to PRN 0: never remapped, never freed.
          if (i_pkt.entries[i].dest_arn != '0) begin
            o_free_valid[i]                   = 1'b1;
            o_free_prn[i]                     = o_map[i_pkt.entries[i].dest_arn];
            o_map[i_pkt.entries[i].dest_arn]  = i_pkt.entries[i].dest_prn;
          end
          if (i_pkt.entries[i].halt || i_pkt.entries[i].illegal) begin
            w_stop        = 1'b1;
            o_halt_hit    = 1'b1;
            o_illegal_hit = i_pkt.entries[i].illegal;
          end
        end
      end
    end
  end

endmodule

// File: rtl/retire_unit.sv
// Retirement stage top: RUN/HALTED FSM, architectural map register, free-list
// and store-queue pulses, retired-instruction counter.
// Defining RETIRE_TRACE_EN adds per-slot trace outputs for the writeback log.

module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int N           = `N,
  parameter int ARCH_REG_SZ = 32,
  parameter int PHYS_REG_SZ = `PHYS_REG_SZ,
  parameter int CW          = $clog2(N + 1),
  parameter int PRN_W       = $clog2(PHYS_REG_SZ)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  ROB_CT_PACKET                         rob_ct_packet,
  input  logic                                 squash,
  output logic [N-1:0]                         free_valid,
  output logic [N-1:0][PRN_W-1:0]              free_prn,
  output logic [CW-1:0]                        sq_retire_cnt,
  output logic [ARCH_REG_SZ-1:0][PRN_W-1:0]    arch_map,
  output logic                                 recover_valid,
  output logic [63:0]                          retired_cnt,
  output logic                                 halted,
  output logic                                 illegal_seen
`ifdef RETIRE_TRACE_EN
  ,
  output logic [N-1:0]                         trace_valid,
  output logic [N-1:0][31:0]                   trace_pc,
  output logic [N-1:0][PRN_W-1:0]              trace_prn,
  output logic [N-1:0][ARN_W-1:0]              trace_arn
`endif
);

  RETIRE_STATE r_state, w_state_next;
  logic [ARCH_REG_SZ-1:0][PRN_W-1:0] r_map, w_map_next;
  logic [N-1:0]            r_free_valid, w_free_valid;
  logic [N-1:0][PRN_W-1:0] r_free_prn, w_free_prn;
  logic [CW-1:0]           r_sq_cnt, w_store_cnt, w_retire_cnt;
  logic                    r_recover, r_illegal;
  logic [63:0]             r_retired_cnt;
  logic                    w_halt_hit, w_illegal_hit, w_run;

  retire_map_update #(
    .N           (N),
    .ARCH_REG_SZ (ARCH_REG_SZ),
    .CW          (CW)
  ) u_map_update (
    .i_map         (r_map),
    .i_pkt         (rob_ct_packet),
    .o_map         (w_map_next),
    .o_free_valid  (w_free_valid),
    .o_free_prn    (w_free_prn),
    .o_retire_cnt  (w_retire_cnt),
    .o_store_cnt   (w_store_cnt),
    .o_halt_hit    (w_halt_hit),
    .o_illegal_hit (w_illegal_hit)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  // Next state: the first halting/illegal slot stops the core until reset.
  always_comb begin
    w_state_next = r_state;
    w_run        = (r_state == RUN);
    if (w_run && w_halt_hit) w_state_next = HALTED;
  end

  // Datapath registers: commit in RUN, freeze (pulses cleared) in HALTED.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REG_SZ; i++) r_map[i] <= PRN_W'(i);
      r_free_valid  <= '0;
      r_free_prn    <= '0;
      r_sq_cnt      <= '0;
      r_recover     <= 1'b0;
      r_retired_cnt <= '0;
      r_illegal     <= 1'b0;
    end else if (w_run) begin
      r_map         <= w_map_next;
      r_free_valid  <= w_free_valid;
      r_free_prn    <= w_free_prn;
      r_sq_cnt      <= w_store_cnt;
      r_recover     <= squash;
      r_retired_cnt <= r_retired_cnt + 64'(w_retire_cnt);
      if (w_halt_hit) r_illegal <= w_illegal_hit;
    end else begin
      r_free_valid  <= '0;
      r_free_prn    <= '0;
      r_sq_cnt      <= '0;
      r_recover     <= 1'b0;
    end
  end

  assign free_valid    = r_free_valid;
  assign free_prn      = r_free_prn;
  assign sq_retire_cnt = r_sq_cnt;
  assign arch_map      = r_map;
  assign recover_valid = r_recover;
  assign retired_cnt   = r_retired_cnt;
  assign halted        = (r_state == HALTED);
  assign illegal_seen  = r_illegal;

`ifdef RETIRE_TRACE_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_trace
    // Per-slot trace capture, same timing as the free pulses.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        trace_valid[gi] <= 1'b0;
        trace_pc[gi]    <= '0;
        trace_prn[gi]   <= '0;
        trace_arn[gi]   <= '0;
      end else if (w_run && (CW'(gi) < w_retire_cnt)) begin
        trace_valid[gi] <= 1'b1;
        trace_pc[gi]    <= rob_ct_packet.entries[gi].PC;
        trace_prn[gi]   <= rob_ct_packet.entries[gi].dest_prn;
        trace_arn[gi]   <= rob_ct_packet.entries[gi].dest_arn;
      end else begin
        trace_valid[gi] <= 1'b0;
        trace_pc[gi]    <= '0;
        trace_prn[gi]   <= '0;
        trace_arn[gi]   <= '0;
      end
    end
  end
`endif

endmodule
